cnn_hls_sdiv_32s_32s_32_seq_1: RTL and testbench

Sequential signed integer divider for the CNN HLS datapath. It is the inverse arithmetic counterpart of the pipelined `cnn_hls_mul_*` multiplier cores and is used for requantisation and average-pool normalisation. Operands enter on a start/ready handshake, and the quotient and remainder are computed one bit per cycle with a restoring algorithm. Results are registered, qualified by a one-cycle `done` pulse, and held until the next operation.

---
 rtl/cnn_hls_sdiv_32s_32s_32_seq_1.sv | 160 ++++++++++++++++
 tb/tb_cnn_hls_sdiv_32s_32s_32_seq_1.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_hls_sdiv_32s_32s_32_seq_1.sv
// -----------------------------------------------------------------------------
// cnn_hls_sdiv_32s_32s_32_seq_1
//
// Sequential signed integer divider (restoring, one quotient bit per cycle).
// The quotient truncates toward zero and the remainder takes the sign of the
// dividend (C semantics). Results are registered and held until the next
// operation finishes its FIX step.
//
// Optional feature macro: CNN_HLS_SDIV_ZERO_SAT_EN
//   defined   : divide by zero saturates the quotient (0x7FF.. / 0x800..)
//   undefined : divide by zero returns the natural algorithm result
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   ce     in   clock enable; 0 freezes every register
//   start  in   operation request
//   din0   in   signed dividend
//   din1   in   signed divisor
//   ready  out  high while idle (able to accept start)
//   done   out  result-valid pulse
//   dout   out  signed quotient
//   rem    out  signed remainder
//   dbz    out  divide-by-zero flag of the last result
//
// Handshake: a request is accepted on a rising edge where start=1, ready=1
// and ce=1; start at any other time is ignored (no queueing). done is high
// for one enabled cycle when dout/rem/dbz are updated; ready rises one cycle
// after done. dout/rem/dbz stay stable until the next result is loaded.
// -----------------------------------------------------------------------------
module cnn_hls_sdiv_32s_32s_32_seq_1 #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 0,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [dout_WIDTH-1:0] rem,
    output logic                  dbz
);

    localparam int W  = din0_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST  = CW'(W - 1);
    localparam logic [CW-1:0] CNT1  = CW'(1);
    localparam logic [W-1:0]  ONE   = W'(1);
    // Tag parameters carry no function in this core.
    localparam int unused_cfg = ID + NUM_STAGE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    // Dividend magnitude shifts out MSB-first while quotient bits shift in.
    logic [W-1:0]  dvd_q;
    logic [W-1:0]  dvs;
    logic [W:0]    part;
    logic          q_neg;
    logic          r_neg;
    logic          zero_div;

    logic [W:0]    shifted;
    logic [W:0]    trial;

    always_comb begin
        shifted = {part[W-1:0], dvd_q[W-1]};
        trial   = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            dout     <= '0;
            rem      <= '0;
            dbz      <= 1'b0;
            cnt      <= '0;
            dvd_q    <= '0;
            dvs      <= '0;
            part     <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            zero_div <= 1'b0;
        end else if (ce) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Magnitudes as unsigned W-bit values; the most
                        // negative number maps onto itself, which is exactly
                        // its unsigned magnitude.
                        dvd_q    <= din0[W-1] ? (~din0 + ONE) : din0;
                        dvs      <= din1[W-1] ? (~din1 + ONE) : din1;
                        q_neg    <= din0[W-1] ^ din1[W-1];
                        r_neg    <= din0[W-1];
                        zero_div <= (din1 == '0);
                        part     <= '0;
                        cnt      <= '0;
                        ready    <= 1'b0;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Non-negative trial (top bit clear) keeps the difference.
                    if (!trial[W]) begin
                        part  <= trial;
                        dvd_q <= {dvd_q[W-2:0], 1'b1};
                    end else begin
                        part  <= shifted;
                        dvd_q <= {dvd_q[W-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT1;
                    if (cnt == LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
`ifdef CNN_HLS_SDIV_ZERO_SAT_EN
                    if (zero_div) begin
                        dout <= r_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                    end else begin
                        dout <= q_neg ? (~dvd_q + ONE) : dvd_q;
                    end
`else
                    dout <= q_neg ? (~dvd_q + ONE) : dvd_q;
`endif
                    rem   <= r_neg ? (~part[W-1:0] + ONE) : part[W-1:0];
                    dbz   <= zero_div;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_hls_sdiv_32s_32s_32_seq_1.sv
// -----------------------------------------------------------------------------
// Bench for cnn_hls_sdiv_32s_32s_32_seq_1: directed corner cases plus random
// operands, compared against a C-semantics division model.
// -----------------------------------------------------------------------------
module tb_cnn_hls_sdiv_32s_32s_32_seq_1;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        start;
    logic [31:0] din0;
    logic [31:0] din1;
    logic        ready;
    logic        done;
    logic [31:0] dout;
    logic [31:0] rem;
    logic        dbz;

    int n_vec;
    int n_err;

    cnn_hls_sdiv_32s_32s_32_seq_1 #(
        .ID(1), .NUM_STAGE(0), .din0_WIDTH(32), .din1_WIDTH(32), .dout_WIDTH(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .ready (ready),
        .done  (done),
        .dout  (dout),
        .rem   (rem),
        .dbz   (dbz)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (C division) ----------------
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic z);
        int sa;
        int sb;
        sa = a;
        sb = b;
        z  = (b == 32'd0);
        if (z) begin
`ifdef CNN_HLS_SDIV_ZERO_SAT_EN
            q = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
            q = (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
`endif
            r = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", {31'd0, ready}, 32'd1);
    endtask

    // One division; optional ce stall of stall_n cycles mid-CALC and an
    // optional ignored start pulse while busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int stall_n, input bit busy);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          lat;
        ref_div(a, b, eq, er, ez);
        wait_ready();
        start = 1'b1;
        din0  = a;
        din1  = b;
        ce    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (lat < 200) begin
            ce    = !(lat >= 10 && lat < 10 + stall_n);
            start = busy && (lat == 5);
            if (start) begin
                din0 = $urandom;
                din1 = $urandom;
            end
            @(negedge clk);
            lat++;
            if (done) break;
        end
        start = 1'b0;
        ce    = 1'b1;
        check("latency", lat, 33 + stall_n);
        check("dout", dout, eq);
        check("rem", rem, er);
        check("dbz", {31'd0, dbz}, {31'd0, ez});
        check("ready_busy", {31'd0, ready}, 32'd0);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("ready_back", {31'd0, ready}, 32'd1);
        check("dout_hold", dout, eq);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_dout"}, dout, 32'd0);
        check({tag, "_rem"}, rem, 32'd0);
        check({tag, "_dbz"}, {31'd0, dbz}, 32'd0);
    endtask

    task automatic watch_no_done(input string tag);
        int seen;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(tag, seen, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_vals("rst");

        run_op(32'd100, 32'd7, 0, 0);
        run_op(-32'sd100, 32'd7, 0, 0);
        run_op(32'd100, -32'sd7, 0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(32'd100, 32'd0, 0, 0);
        run_op(-32'sd5, 32'd0, 0, 0);
        run_op(32'h8000_0000, 32'd0, 0, 0);
        run_op(32'h8000_0000, 32'd1, 0, 0);
        run_op(32'd1000, 32'd10, 5, 0);
        run_op(32'd12345, -32'sd77, 0, 1);
        run_op(32'd7, 32'd100, 0, 0);
        run_op(32'd0, -32'sd3, 0, 0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 0, 0);

        // Reset during CALC aborts the operation.
        wait_ready();
        start = 1'b1;
        din0  = 32'd1000;
        din1  = 32'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("abort");
        watch_no_done("abort_no_done");

        // Reset and start together: start is dropped.
        reset = 1'b1;
        start = 1'b1;
        din0  = 32'd100;
        din1  = 32'd7;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_ready", {31'd0, ready}, 32'd1);
        watch_no_done("rst_start_no_done");

        // Random operands.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            sel = $urandom_range(0, 7);
            a   = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(0, 5000) - 2500);
            if (sel == 0)
                b = 32'd0;
            else if (sel < 4)
                b = ($urandom_range(0, 1) == 1) ? -$urandom_range(1, 20) : $urandom_range(1, 20);
            else if (sel == 4)
                b = 32'hFFFF_FFFF;
            else
                b = $urandom;
            run_op(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
